// File: rtl/rec_elink_pkg.sv
// Shared constants and helpers for the e-link receive frame FIFO:
// register addresses, frame width and frame packing.
package rec_elink_pkg;

    localparam logic [4:0] ADDR_ID        = 5'b00101;
    localparam logic [4:0] ADDR_DATA_BASE = 5'd0;
    localparam int         MAX_NBYTES     = 8;
    localparam int         MAX_FRAME_W    = 12 + 8 * MAX_NBYTES;

    function automatic int frame_w(input int nbytes);
        return 12 + 8 * nbytes;
    endfunction

    // Payload is right-aligned with b1 in its top byte; the id sits just above it.
    function automatic logic [MAX_FRAME_W-1:0] pack_frame(input logic [10:0] id,
                                                          input logic [63:0] payload,
                                                          input int          nbytes);
        logic [MAX_FRAME_W-1:0] f;
        f = {12'd0, payload};
        f = f | ({65'd0, id} << (8 * nbytes));
        return f;
    endfunction

endpackage

// File: rtl/rec_elink_frame_fifo.sv
// Generic first-word-fall-through synchronous FIFO; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module rec_elink_frame_fifo #(
    parameter int WIDTH = 76,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_en, rd_en;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign fill  = wr_ptr_q - rd_ptr_q;
    assign dout  = mem[rd_ptr_q[AW-1:0]];

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset so it maps onto plain memory.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/rec_elink_fifo.sv
// Assembles CAN frames from CANakari register reads into a staging register
// and queues each committed frame toward the e-link transmit path.
module rec_elink_fifo
    import rec_elink_pkg::*;
#(
    parameter int         NBYTES  = 8,
    parameter int         DEPTH   = 4,
    parameter logic [4:0] ID_ADDR = ADDR_ID
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [15:0]                 data_rec_in,
    input  logic                        buffer_en,
    input  logic [4:0]                  addr,
    input  logic                        commit,
    input  logic                        clr_ovf,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [12+8*NBYTES-1:0]      data_rec_out,
    output logic [$clog2(DEPTH):0]      fill,
    output logic                        overflow
);
    localparam int FW     = frame_w(NBYTES);
    localparam int PW     = 8 * NBYTES;
    localparam int NPAIRS = NBYTES / 2;

    logic [10:0]       id_q, id_d;
    logic [PW-1:0]     bytes_q, bytes_d;
    logic              ovf_q, ovf_d;
    logic [NPAIRS-1:0] pair_we;
    logic [FW-1:0]     frame_push;
    logic [FW-1:0]     fifo_dout;
    logic              fifo_full, fifo_empty, pop, drop;

    // Address P loads the byte pair that sits at bits [16P+15:16P] of the payload.
    genvar gi;
    generate
        for (gi = 0; gi < NPAIRS; gi++) begin : g_pair
            assign pair_we[gi] = buffer_en && (addr == ADDR_DATA_BASE + 5'(gi));
        end
    endgenerate

    assign frame_push = FW'(pack_frame(id_q, 64'(bytes_q), NBYTES));
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    assign drop       = commit && fifo_full && !pop;

    always_comb begin
        id_d    = commit ? '0 : id_q;
        bytes_d = commit ? '0 : bytes_q;
        if (buffer_en && addr == ID_ADDR) id_d = data_rec_in[15:5];
        for (int p = 0; p < NPAIRS; p++) begin
            if (pair_we[p]) bytes_d[16*p +: 16] = data_rec_in;
        end
        ovf_d = ovf_q;
        if (clr_ovf) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_q    <= '0;
            bytes_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            id_q    <= id_d;
            bytes_q <= bytes_d;
            ovf_q   <= ovf_d;
        end
    end

    rec_elink_frame_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (commit),
        .pop   (pop),
        .din   (frame_push),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .fill  (fill)
    );

    assign data_rec_out = out_valid ? fifo_dout : '0;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_rec_elink_fifo.sv
// Directed bench for rec_elink_fifo: default 8-byte/4-deep instance plus a
// 2-byte/2-deep instance.
module tb_rec_elink_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_rec_in;
    logic        buffer_en, commit, clr_ovf, out_ready;
    logic        out_valid, overflow;
    logic [75:0] data_rec_out;
    logic [2:0]  fill;

    logic [15:0] s_data_in;
    logic [4:0]  s_addr;
    logic [4:0]  addr;
    logic        s_buffer_en, s_commit, s_clr_ovf, s_out_ready;
    logic        s_out_valid, s_overflow;
    logic [27:0] s_data_out;
    logic [1:0]  s_fill;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rec_elink_fifo #(.NBYTES(8), .DEPTH(4), .ID_ADDR(5'b00101)) dut (
        .clk(clk), .rst(rst), .data_rec_in(data_rec_in), .buffer_en(buffer_en),
        .addr(addr), .commit(commit), .clr_ovf(clr_ovf), .out_valid(out_valid),
        .out_ready(out_ready), .data_rec_out(data_rec_out), .fill(fill),
        .overflow(overflow)
    );

    rec_elink_fifo #(.NBYTES(2), .DEPTH(2), .ID_ADDR(5'b00101)) dut_small (
        .clk(clk), .rst(rst), .data_rec_in(s_data_in), .buffer_en(s_buffer_en),
        .addr(s_addr), .commit(s_commit), .clr_ovf(s_clr_ovf), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .data_rec_out(s_data_out), .fill(s_fill),
        .overflow(s_overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [15:0] d);
        addr = a; data_rec_in = d; buffer_en = 1'b1;
        tick();
        buffer_en = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        $display("commit: out_valid=%0b fill=%0d overflow=%0b head=%h", out_valid, fill, overflow, data_rec_out);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_checks++; if (fill !== 3'd0) begin n_fail++; $display("FAIL reset_fill: got %0d expected 0", fill); end
        n_checks++; if (data_rec_out !== 76'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", data_rec_out); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        n_checks++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_small_valid: got %b expected 0", s_out_valid); end
    endtask

    task automatic test_basic_frame();
        write_reg(5'd5, 16'hC0A0);
        write_reg(5'd3, 16'h0102);
        write_reg(5'd2, 16'h0304);
        write_reg(5'd1, 16'h0506);
        write_reg(5'd0, 16'h0708);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pre_valid: got %b expected 0", out_valid); end
        do_commit();
        // id = 16'hC0A0 >> 5 = 11'h605
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
        n_checks++; if (data_rec_out !== {12'h605, 64'h0102030405060708}) begin
            n_fail++; $display("FAIL basic_data: got %h expected %h", data_rec_out, {12'h605, 64'h0102030405060708}); end
        n_checks++; if (fill !== 3'd1) begin n_fail++; $display("FAIL basic_fill: got %0d expected 1", fill); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop_valid: got %b expected 0", out_valid); end
        n_checks++; if (data_rec_out !== 76'd0) begin n_fail++; $display("FAIL basic_pop_mask: got %h expected 0", data_rec_out); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            write_reg(5'd5, {11'(i), 5'd0});
            do_commit();
        end
        n_checks++; if (fill !== 3'd4) begin n_fail++; $display("FAIL ovf_fill4: got %0d expected 4", fill); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: got %b expected 0", overflow); end
        write_reg(5'd5, {11'd5, 5'd0});
        do_commit();
        n_checks++; if (fill !== 3'd4) begin n_fail++; $display("FAIL ovf_fill_after: got %0d expected 4", fill); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        n_checks++; if (data_rec_out !== {1'b0, 11'd1, 64'd0}) begin
            n_fail++; $display("FAIL ovf_head_hold: got %h expected %h", data_rec_out, {1'b0, 11'd1, 64'd0}); end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_checks++; if (data_rec_out !== {1'b0, 11'(i), 64'd0} || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL ovf_pop_order: got valid=%b %h expected valid=1 %h", out_valid, data_rec_out, {1'b0, 11'(i), 64'd0}); end
            tick();
        end
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b expected 0 (id 5 must be absent)", out_valid); end
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_full_with_pop();
        out_ready = 1'b0;
        for (int i = 11; i <= 14; i++) begin
            write_reg(5'd5, {11'(i), 5'd0});
            do_commit();
        end
        write_reg(5'd5, {11'd15, 5'd0});
        out_ready = 1'b1;
        do_commit();
        out_ready = 1'b0;
        n_checks++; if (fill !== 3'd4) begin n_fail++; $display("FAIL fullpop_fill: got %0d expected 4", fill); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf: got %b expected 0", overflow); end
        out_ready = 1'b1;
        for (int i = 12; i <= 15; i++) begin
            n_checks++; if (data_rec_out !== {1'b0, 11'(i), 64'd0}) begin
                n_fail++; $display("FAIL fullpop_order: got %h expected %h", data_rec_out, {1'b0, 11'(i), 64'd0}); end
            tick();
        end
        out_ready = 1'b0;
        n_checks++; if (fill !== 3'd0) begin n_fail++; $display("FAIL fullpop_empty: got %0d expected 0", fill); end
    endtask

    task automatic test_commit_with_write();
        write_reg(5'd5, {11'd7, 5'd0});
        write_reg(5'd3, 16'h1111);
        addr = 5'd3; data_rec_in = 16'hAABB; buffer_en = 1'b1;
        do_commit();
        buffer_en = 1'b0;
        n_checks++; if (data_rec_out !== {1'b0, 11'd7, 16'h1111, 48'd0}) begin
            n_fail++; $display("FAIL samecyc_old: got %h expected %h", data_rec_out, {1'b0, 11'd7, 16'h1111, 48'd0}); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        do_commit();
        n_checks++; if (data_rec_out !== {12'h000, 16'hAABB, 48'd0}) begin
            n_fail++; $display("FAIL samecyc_new: got %h expected %h", data_rec_out, {12'h000, 16'hAABB, 48'd0}); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_small();
        s_addr = 5'd0; s_data_in = 16'h1122; s_buffer_en = 1'b1;
        tick();
        s_buffer_en = 1'b0; s_commit = 1'b1;
        tick();
        s_commit = 1'b0;
        $display("small commit: out_valid=%0b fill=%0d head=%h", s_out_valid, s_fill, s_data_out);
        n_checks++; if (s_out_valid !== 1'b1) begin n_fail++; $display("FAIL small_valid: got %b expected 1", s_out_valid); end
        n_checks++; if (s_data_out !== 28'h0001122) begin n_fail++; $display("FAIL small_data: got %h expected 0001122", s_data_out); end
        s_commit = 1'b1; tick(); tick(); s_commit = 1'b0;
        n_checks++; if (s_fill !== 2'd2) begin n_fail++; $display("FAIL small_fill: got %0d expected 2", s_fill); end
        n_checks++; if (s_overflow !== 1'b1) begin n_fail++; $display("FAIL small_ovf: got %b expected 1", s_overflow); end
    endtask

    task automatic test_clr_ovf_race();
        out_ready = 1'b0;
        for (int i = 21; i <= 25; i++) begin
            write_reg(5'd5, {11'(i), 5'd0});
            do_commit();
        end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL race_set: got %b expected 1", overflow); end
        clr_ovf = 1'b1;
        do_commit();
        clr_ovf = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL race_set_wins: got %b expected 1", overflow); end
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL race_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        n_checks++; if (fill !== 3'd3) begin n_fail++; $display("FAIL rstq_fill3: got %0d expected 3", fill); end
        write_reg(5'd0, 16'hDEAD);
        rst = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstq_valid: got %b expected 0", out_valid); end
        n_checks++; if (fill !== 3'd0) begin n_fail++; $display("FAIL rstq_fill: got %0d expected 0", fill); end
        n_checks++; if (data_rec_out !== 76'd0) begin n_fail++; $display("FAIL rstq_data: got %h expected 0", data_rec_out); end
        n_checks++; if (s_overflow !== 1'b0) begin n_fail++; $display("FAIL rstq_small_ovf: got %b expected 0", s_overflow); end
        do_commit();
        n_checks++; if (out_valid !== 1'b1 || data_rec_out !== 76'd0) begin
            n_fail++; $display("FAIL rstq_staging_cleared: got valid=%b %h expected valid=1 0", out_valid, data_rec_out); end
    endtask

    initial begin
        rst = 1'b1; data_rec_in = '0; buffer_en = 1'b0; addr = '0;
        commit = 1'b0; clr_ovf = 1'b0; out_ready = 1'b0;
        s_data_in = '0; s_addr = '0; s_buffer_en = 1'b0; s_commit = 1'b0;
        s_clr_ovf = 1'b0; s_out_ready = 1'b0;
        #1;
        test_reset();
        test_basic_frame();
        test_overflow();
        test_full_with_pop();
        test_commit_with_write();
        test_small();
        test_clr_ovf_race();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
